// File: rtl/lsu_ram_ctrl_pkg.sv
// Shared encodings and helpers for the load/store front-end.
package lsu_pkg;

    // Request size encodings
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Controller FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    // Request error: illegal size, or a half/word not naturally aligned
    function automatic logic req_error(input logic [1:0] size, input logic [1:0] off);
        logic err;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = off[0];
            SZ_WORD: err = (off != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_ram_ctrl_lane_align.sv
// Byte-lane alignment: load extraction/extension and sub-word store merge.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane(s) out of the RAM word and extend them
    always_comb begin
        byte_sel  = word[{offset, 3'b000} +: 8];
        half_sel  = offset[1] ? word[31:16] : word[15:0];
        load_data = '0;
        case (size)
            SZ_BYTE: load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            SZ_WORD: load_data = word;
            default: load_data = '0;
        endcase
    end

    // Replace the addressed lane(s) with store data, keep the rest of the word
    always_comb begin
        store_word = word;
        case (size)
            SZ_BYTE: store_word[{offset, 3'b000} +: 8]    = wdata[7:0];
            SZ_HALF: store_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            SZ_WORD: store_word = wdata;
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/lsu_ram_ctrl.sv
// Load/store front-end for simple_ram: handshake, RMW for sub-word stores.
module lsu_ram_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [31:0]       ram_addr,
    output logic [31:0]       ram_data,
    output logic              ram_wr,
    input  logic [31:0]       ram_q
);

    state_t            state;
    logic              lat_we;
    logic [1:0]        lat_size;
    logic [1:0]        lat_off;
    logic              lat_uns;
    logic [31:0]       lat_wdata;
    logic              accept;
    logic              acc_err;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       load_data;
    logic [31:0]       store_word;

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign ram_wr    = (state == ST_WRITE) & ~rst;
    assign accept    = req_valid & req_ready;
    assign acc_err   = req_error(req_size, req_addr[1:0]);
    assign word_addr = req_addr >> 2;

    lsu_lane_align u_align (
        .offset      (lat_off),
        .size        (lat_size),
        .is_unsigned (lat_uns),
        .word        (ram_q),
        .wdata       (lat_wdata),
        .load_data   (load_data),
        .store_word  (store_word)
    );

    // FSM, request latch, RAM address/data and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            lat_we    <= 1'b0;
            lat_size  <= SZ_BYTE;
            lat_off   <= '0;
            lat_uns   <= 1'b0;
            lat_wdata <= '0;
            ram_addr  <= '0;
            ram_data  <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_we    <= req_we;
                        lat_size  <= req_size;
                        lat_off   <= req_addr[1:0];
                        lat_uns   <= req_unsigned;
                        lat_wdata <= req_wdata;
                        ram_addr  <= 32'(word_addr);
                        rsp_rdata <= '0;
                        rsp_err   <= acc_err;
                        if (acc_err) begin
                            state <= ST_RESP;
                        end else if (req_we && req_size == SZ_WORD) begin
                            ram_data <= req_wdata;
                            state    <= ST_WRITE;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_READ: state <= ST_CAPTURE;
                ST_CAPTURE: begin
                    if (lat_we) begin
                        ram_data <= store_word;
                        state    <= ST_WRITE;
                    end else begin
                        rsp_rdata <= load_data;
                        state     <= ST_RESP;
                    end
                end
                ST_WRITE: state <= ST_RESP;
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ram_ctrl.sv
// Scoreboard bench for lsu_ram_ctrl with a behavioural simple_ram.
module tb_lsu_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] ram_addr;
    logic [31:0] ram_data;
    logic        ram_wr;
    logic [31:0] ram_q;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    logic seen = 1'b0;

    // simple_ram model
    logic [31:0] mem [16] = '{default: '0};
    int          wr_cnt = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    lsu_ram_ctrl #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_addr     (ram_addr),
        .ram_data     (ram_data),
        .ram_wr       (ram_wr),
        .ram_q        (ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read RAM with write strobe
    always @(posedge clk) begin
        if (ram_wr) begin
            mem[ram_addr[3:0]] <= ram_data;
            wr_cnt             <= wr_cnt + 1;
            last_wr_addr       <= ram_addr;
            last_wr_data       <= ram_data;
        end
        ram_q <= mem[ram_addr[3:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Response monitor: pop on first valid cycle, check latency and hold fields
    always @(negedge clk) begin
        if (!rsp_valid) begin
            seen = 1'b0;
        end else begin
            if (!seen) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                    cur = '{rdata: rsp_rdata, err: rsp_err, lat: 0, acc: cyc};
                end else begin
                    cur = exp_q.pop_front();
                    chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                end
                seen = 1'b1;
            end
            chk("rsp_rdata", rsp_rdata, cur.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(cur.err));
        end
    end

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 32'd0, 32'd1);
            return;
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = exp_lat;
        e.acc   = cyc - 1;
        exp_q.push_back(e);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || seen) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({pfx, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({pfx, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({pfx, "_ram_addr"}, ram_addr, 32'd0);
        chk({pfx, "_ram_data"}, ram_data, 32'd0);
        chk({pfx, "_ram_wr"}, 32'(ram_wr), 32'd0);
    endtask

    initial begin
        int w0;
        logic [31:0] refm [4];
        logic [31:0] tmp;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_values("reset");

        // Word store then load
        w0 = wr_cnt;
        issue(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        wait_done();
        chk("wst_wr_count", 32'(wr_cnt - w0), 32'd1);
        chk("wst_wr_addr", last_wr_addr, 32'd2);
        chk("wst_wr_data", last_wr_data, 32'hDEADBEEF);
        issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0, 3);
        wait_done();

        // Byte store read-modify-write
        issue(1'b1, 2'b10, 1'b0, 32'h4, 32'h11223344, 32'h0, 1'b0, 2);
        wait_done();
        issue(1'b1, 2'b00, 1'b0, 32'h6, 32'h000000AA, 32'h0, 1'b0, 4);
        wait_done();
        chk("bst_mem", mem[1], 32'h11AA3344);
        issue(1'b0, 2'b00, 1'b0, 32'h6, 32'h0, 32'hFFFFFFAA, 1'b0, 3);
        issue(1'b0, 2'b00, 1'b1, 32'h6, 32'h0, 32'h000000AA, 1'b0, 3);
        issue(1'b0, 2'b00, 1'b0, 32'h4, 32'h0, 32'h00000044, 1'b0, 3);
        wait_done();

        // Half loads
        issue(1'b1, 2'b10, 1'b0, 32'h4, 32'h80017FFE, 32'h0, 1'b0, 2);
        issue(1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 32'hFFFF8001, 1'b0, 3);
        issue(1'b0, 2'b01, 1'b1, 32'h4, 32'h0, 32'h00007FFE, 1'b0, 3);
        issue(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 32'h00008001, 1'b0, 3);
        issue(1'b0, 2'b00, 1'b0, 32'h7, 32'h0, 32'hFFFFFF80, 1'b0, 3);
        issue(1'b1, 2'b01, 1'b0, 32'h6, 32'hFFFF0012, 32'h0, 1'b0, 4);
        issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h00127FFE, 1'b0, 3);
        wait_done();

        // Errors: no RAM write, latency 1, rdata 0
        w0 = wr_cnt;
        issue(1'b0, 2'b01, 1'b0, 32'h5, 32'h0, 32'h0, 1'b1, 1);
        issue(1'b1, 2'b10, 1'b0, 32'h2, 32'h12345678, 32'h0, 1'b1, 1);
        issue(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1);
        issue(1'b1, 2'b11, 1'b0, 32'h8, 32'hCAFEF00D, 32'h0, 1'b1, 1);
        wait_done();
        chk("err_no_write", 32'(wr_cnt - w0), 32'd0);
        chk("err_mem2", mem[2], 32'hDEADBEEF);

        // Backpressure: response held, new request refused
        w0 = wr_cnt;
        rsp_ready = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0, 3);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_size  = 2'b10;
            req_addr  = 32'h10;
            req_wdata = 32'h55555555;
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            if (i >= 2) chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            if (i >= 2) chk("bp_ram_addr", ram_addr, 32'd2);
        end
        #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_done();
        repeat (4) @(negedge clk);
        chk("bp_no_write", 32'(wr_cnt - w0), 32'd0);
        chk("bp_mem4", mem[4], 32'h0);

        // Reset during WRITE of a byte store
        w0 = wr_cnt;
        issue(1'b1, 2'b00, 1'b0, 32'h5, 32'h00000077, 32'h0, 1'b0, 4);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rw_wr_before_rst", 32'(ram_wr), 32'd1);
        rst = 1'b1;
        #1;
        chk("rw_wr_forced_low", 32'(ram_wr), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset_values("rw");
        chk("rw_mem1", mem[1], 32'h00127FFE);
        chk("rw_no_write", 32'(wr_cnt - w0), 32'd0);

        // Randomised byte stores checked through word loads
        for (int i = 0; i < 4; i++) begin
            refm[i] = $urandom;
            issue(1'b1, 2'b10, 1'b0, 32'(32 + 4 * i), refm[i], 32'h0, 1'b0, 2);
        end
        for (int i = 0; i < 6; i++) begin
            int idx;
            int off;
            logic [7:0] b;
            idx = $urandom_range(0, 3);
            off = $urandom_range(0, 3);
            b   = 8'($urandom);
            tmp = refm[idx];
            tmp[off * 8 +: 8] = b;
            refm[idx] = tmp;
            issue(1'b1, 2'b00, 1'b0, 32'(32 + 4 * idx + off), {24'hABCDEF, b}, 32'h0, 1'b0, 4);
            issue(1'b0, 2'b10, 1'b0, 32'(32 + 4 * idx), 32'h0, tmp, 1'b0, 3);
            issue(1'b0, 2'b00, 1'b1, 32'(32 + 4 * idx + off), 32'h0, {24'h0, b}, 1'b0, 3);
        end
        wait_done();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
